// File: rtl/seq_pattern_gen_if.sv
// Serial pattern generator control/data bundle.
// The requester drives the master side; the generator uses the slave side.
interface seq_pattern_gen_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] gap_len;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, rep_cnt, gap_len,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, rep_cnt, gap_len,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first
// for a programmable number of repetitions, with optional idle gaps between them.
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  seq_pattern_gen_if.slave bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic; outputs are the registered copies.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start && !bus.abort) begin
          pat_d  = bus.pattern;
          rep_d  = bus.rep_cnt;
          gap_d  = bus.gap_len;
          busy_d = 1'b1;
          if (bus.rep_cnt != '0) begin
            state_d = S_SHIFT;
            idx_d   = MSB_IDX;
            dout_d  = bus.pattern[PAT_W-1];
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - IDX_W'(1);
          dout_d  = pat_q[idx_d];
          valid_d = 1'b1;
        end else begin
          // LSB just went out: one repetition complete.
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end else begin
            idx_d   = MSB_IDX;
            dout_d  = pat_q[PAT_W-1];
            valid_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        // gcnt_q holds the gap cycles remaining, including the current one.
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (gcnt_q == CNT_W'(1)) begin
          state_d = S_SHIFT;
          gcnt_d  = '0;
          idx_d   = MSB_IDX;
          dout_d  = pat_q[PAT_W-1];
          valid_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: per-cycle {dout,dout_valid,busy,done}
// compared against a stream built from the transfer rules.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [3:0] exp_q[$];

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {bus.dout, bus.dout_valid, bus.busy, bus.done};
  endfunction

  // Expected cycle stream from the first post-start edge: bits, gaps, done, then idle.
  function automatic void build(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    exp_q.delete();
    for (int r = 0; r < rep; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic kick(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.rep_cnt = CNT_W'(rep);
    bus.gap_len = CNT_W'(gap);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.pattern = PAT_W'($urandom);
    bus.rep_cnt = CNT_W'($urandom);
    bus.gap_len = CNT_W'($urandom);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.rep_cnt = '0; bus.gap_len = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 4'b0000) begin
      n_fail++; $display("FAIL reset_hold: got %b want 0000", obs());
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 4'b0000) begin
        n_fail++; $display("FAIL reset_release_idle: got %b want 0000", obs());
      end
    end
  endtask

  task automatic test_single();
    build(4'b1011, 1, 0);
    kick(4'b1011, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL single cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] win;
    int nbits, hits;
    win = '0; nbits = 0; hits = 0;
    build(4'b1011, 3, 0);
    kick(4'b1011, 3, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      if (bus.dout_valid) begin
        win = {win[2:0], bus.dout};
        nbits++;
        if (nbits >= 4 && win == 4'b1011) hits++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (hits != 3 || nbits != 12) begin
      n_fail++; $display("FAIL detector_hits: got hits=%0d bits=%0d want hits=3 bits=12", hits, nbits);
    end
  endtask

  task automatic test_gap();
    int busy_cyc;
    busy_cyc = 0;
    build(4'b1101, 2, 2);
    kick(4'b1101, 2, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL gap cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      if (bus.busy) busy_cyc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy_cyc != 11) begin
      n_fail++; $display("FAIL gap_busy_len: got %0d want 11", busy_cyc);
    end
  endtask

  task automatic test_zero_rep();
    kick(4'b1111, 0, 1);
    n_checks++;
    if (obs() !== 4'b0011) begin
      n_fail++; $display("FAIL zero_rep_done: got %b want 0011", obs());
    end
    bus.start = 1'b1; bus.pattern = 4'b1111; bus.rep_cnt = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      n_checks++;
      if (obs() !== 4'b0000) begin
        n_fail++; $display("FAIL zero_rep_start_in_done: got %b want 0000", obs());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    build(4'b1001, 4, 0);
    kick(4'b1001, 4, 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL abort_pre cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      if (i == 2) begin bus.start = 1'b1; bus.pattern = 4'b0110; bus.rep_cnt = 8'd1; end
      if (i == 3) bus.start = 1'b0;
      if (i == 5) bus.abort = 1'b1;
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    repeat (3) begin
      n_checks++;
      if (obs() !== 4'b0000) begin
        n_fail++; $display("FAIL abort_idle: got %b want 0000", obs());
      end
      @(posedge clk); #1;
    end
    // abort and start together in IDLE: abort wins
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.rep_cnt = 8'd2; bus.pattern = 4'b1010;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    n_checks++;
    if (obs() !== 4'b0000) begin
      n_fail++; $display("FAIL abort_beats_start: got %b want 0000", obs());
    end
    build(4'b0111, 2, 1);
    kick(4'b0111, 2, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL after_abort cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    build(4'b1101, 2, 3);
    kick(4'b1101, 2, 3);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL areset_pre cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 4'b0000) begin
      n_fail++; $display("FAIL areset_immediate: got %b want 0000", obs());
    end
    @(negedge clk) reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 4'b0000) begin
        n_fail++; $display("FAIL areset_idle: got %b want 0000", obs());
      end
    end
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] pat;
    int rep, gap;
    for (int t = 0; t < 25; t++) begin
      pat = PAT_W'($urandom);
      rep = $urandom_range(0, 5);
      gap = $urandom_range(0, 3);
      build(pat, rep, gap);
      kick(pat, rep, gap);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random t%0d pat=%b rep=%0d gap=%0d cyc %0d: got %b want %b",
                   t, pat, rep, gap, i, obs(), exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_max_counts();
    build(4'b1100, 255, 0);
    kick(4'b1100, 255, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL max_rep cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
    build(4'b0101, 2, 255);
    kick(4'b0101, 2, 255);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs() !== exp_q[i]) begin
        n_fail++; $display("FAIL max_gap cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_zero_rep();
    test_abort();
    test_async_reset();
    test_random();
    test_max_counts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
